// File: rtl/sub16sat_step.sv
// Sequenced saturating subtractor: repeatedly subtracts a signed step from a
// 16-bit accumulator and streams each result over a valid/ready handshake.
module sub16sat_step #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          resetl,
    input  logic          start,
    input  logic [15:0]   init,
    input  logic [15:0]   delta,
    input  logic [CW-1:0] count,
    input  logic          sat,
    input  logic          eightbit,
    output logic          busy,
    output logic [15:0]   r,
    output logic          rsat,
    output logic          rvalid,
    input  logic          rready,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        HOLD,
        DONE
    } state_t;

    state_t        state;
    logic [15:0]   acc;
    logic [15:0]   d;
    logic [CW-1:0] rem;
    logic          sat_en;
    logic          lane8;

    logic [17:0]   t;
    logic [9:0]    tl;
    logic [7:0]    th;
    logic [7:0]    lo;
    logic [15:0]   nxt;
    logic          nxt_sat;

    // 18 bits: unsigned 16-bit minus signed 16-bit spans -32767..98303.
    always_comb begin
        t       = {2'b00, acc} - {{2{d[15]}}, d};
        tl      = {2'b00, acc[7:0]} - {{2{d[7]}}, d[7:0]};
        th      = acc[15:8] - d[15:8];
        lo      = tl[7:0];
        nxt     = t[15:0];
        nxt_sat = 1'b0;
        if (lane8) begin
            if (sat_en && tl[9]) begin
                lo      = 8'h00;
                nxt_sat = 1'b1;
            end else if (sat_en && tl[8]) begin
                lo      = 8'hFF;
                nxt_sat = 1'b1;
            end
            nxt = {th, lo};
        end else if (sat_en && t[17]) begin
            nxt     = 16'h0000;
            nxt_sat = 1'b1;
        end else if (sat_en && t[16]) begin
            nxt     = 16'hFFFF;
            nxt_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state  <= IDLE;
            busy   <= 1'b0;
            r      <= 16'h0000;
            rsat   <= 1'b0;
            rvalid <= 1'b0;
            done   <= 1'b0;
            acc    <= 16'h0000;
            d      <= 16'h0000;
            rem    <= '0;
            sat_en <= 1'b0;
            lane8  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        acc    <= init;
                        d      <= delta;
                        rem    <= count;
                        sat_en <= sat;
                        lane8  <= eightbit;
                        busy   <= 1'b1;
                        state  <= (count != '0) ? STEP : DONE;
                    end
                end
                STEP: begin
                    r      <= nxt;
                    rsat   <= nxt_sat;
                    acc    <= nxt;
                    rvalid <= 1'b1;
                    rem    <= rem - CW'(1);
                    state  <= HOLD;
                end
                HOLD: begin
                    if (rready) begin
                        if (rem != '0) begin
                            r    <= nxt;
                            rsat <= nxt_sat;
                            acc  <= nxt;
                            rem  <= rem - CW'(1);
                        end else begin
                            rvalid <= 1'b0;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // busy stays high through the done cycle; IDLE drops it
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub16sat_step.sv
// Directed bench for sub16sat_step: hand-computed result streams, back-pressure,
// count=0, ignored mid-run start and asynchronous reset abort.
module tb_sub16sat_step;

    logic        clk = 1'b0;
    logic        resetl;
    logic        start;
    logic [15:0] init;
    logic [15:0] delta;
    logic [7:0]  count;
    logic        sat;
    logic        eightbit;
    logic        busy;
    logic [15:0] r;
    logic        rsat;
    logic        rvalid;
    logic        rready;
    logic        done;

    int checks   = 0;
    int failures = 0;

    sub16sat_step #(.CW(8)) dut (
        .clk      (clk),
        .resetl   (resetl),
        .start    (start),
        .init     (init),
        .delta    (delta),
        .count    (count),
        .sat      (sat),
        .eightbit (eightbit),
        .busy     (busy),
        .r        (r),
        .rsat     (rsat),
        .rvalid   (rvalid),
        .rready   (rready),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [15:0] i0,
                       input logic [15:0] dl, input logic [7:0] cnt,
                       input logic s, input logic e,
                       input logic [15:0] er [5], input logic es [5],
                       input bit poke);
        init     = i0;
        delta    = dl;
        count    = cnt;
        sat      = s;
        eightbit = e;
        rready   = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy0"}, 16'(busy), 16'd1);
        chk({tag, "_rv0"}, 16'(rvalid), 16'd0);
        for (int k = 0; k < int'(cnt); k++) begin
            if (poke && k == 1) begin
                start    = 1'b1;
                init     = 16'hAAAA;
                delta    = 16'h1234;
                count    = 8'd9;
                sat      = ~s;
                eightbit = ~e;
            end
            step();
            start = 1'b0;
            chk($sformatf("%s_r%0d", tag, k), r, er[k]);
            chk($sformatf("%s_rsat%0d", tag, k), 16'(rsat), 16'(es[k]));
            chk($sformatf("%s_rv%0d", tag, k), 16'(rvalid), 16'd1);
            chk($sformatf("%s_dn%0d", tag, k), 16'(done), 16'd0);
        end
        step();
        chk({tag, "_rv_end"}, 16'(rvalid), 16'd0);
        chk({tag, "_done_early"}, 16'(done), 16'd0);
        step();
        chk({tag, "_done"}, 16'(done), 16'd1);
        chk({tag, "_busy_done"}, 16'(busy), 16'd1);
        step();
        chk({tag, "_done_clr"}, 16'(done), 16'd0);
        chk({tag, "_busy_clr"}, 16'(busy), 16'd0);
    endtask

    logic [15:0] bp_exp [4];
    logic        bp_pat [7];
    int          idx;

    initial begin
        resetl   = 1'b0;
        start    = 1'b0;
        init     = 16'h0;
        delta    = 16'h0;
        count    = 8'h0;
        sat      = 1'b0;
        eightbit = 1'b0;
        rready   = 1'b0;
        step();
        step();
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_rvalid", 16'(rvalid), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_rsat", 16'(rsat), 16'd0);
        chk("rst_r", r, 16'h0000);
        resetl = 1'b1;
        step();

        run("dec_sat", 16'h0010, 16'h0004, 8'd5, 1'b1, 1'b0,
            '{16'h000C, 16'h0008, 16'h0004, 16'h0000, 16'h0000},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0);
        run("neg_sat", 16'hFFF0, 16'hFFF8, 8'd3, 1'b1, 1'b0,
            '{16'hFFF8, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
        run("neg_wrap", 16'hFFF0, 16'hFFF8, 8'd3, 1'b0, 1'b0,
            '{16'hFFF8, 16'h0000, 16'h0008, 16'h0, 16'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        // low byte 02-03 and 00-03 both go negative and clamp
        run("lane8", 16'h1205, 16'h0103, 8'd3, 1'b1, 1'b1,
            '{16'h1102, 16'h1000, 16'h0F00, 16'h0, 16'h0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
        run("lane8_hi", 16'h00F0, 16'h00F0, 8'd1, 1'b1, 1'b1,
            '{16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        run("lane8_wrap", 16'h00F0, 16'h00F0, 8'd1, 1'b0, 1'b1,
            '{16'h0000, 16'h0, 16'h0, 16'h0, 16'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        run("poke", 16'h0010, 16'h0004, 8'd5, 1'b1, 1'b0,
            '{16'h000C, 16'h0008, 16'h0004, 16'h0000, 16'h0000},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b1);

        // back-pressure: 4 results, rready 1,0,0,1,0,1,1
        bp_exp = '{16'h00F0, 16'h00E0, 16'h00D0, 16'h00C0};
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        init     = 16'h0100;
        delta    = 16'h0010;
        count    = 8'd4;
        sat      = 1'b0;
        eightbit = 1'b0;
        rready   = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("bp_r_first", r, bp_exp[0]);
        chk("bp_rv_first", 16'(rvalid), 16'd1);
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            rready = bp_pat[c];
            step();
            if (bp_pat[c]) idx++;
            chk($sformatf("bp_done%0d", c), 16'(done), 16'd0);
            if (idx < 4) begin
                chk($sformatf("bp_r%0d", c), r, bp_exp[idx]);
                chk($sformatf("bp_rv%0d", c), 16'(rvalid), 16'd1);
            end else begin
                chk($sformatf("bp_rv%0d", c), 16'(rvalid), 16'd0);
            end
        end
        rready = 1'b0;
        step();
        chk("bp_done", 16'(done), 16'd1);
        chk("bp_rv_done", 16'(rvalid), 16'd0);
        step();
        chk("bp_done_clr", 16'(done), 16'd0);
        chk("bp_busy_clr", 16'(busy), 16'd0);

        // count = 0
        count  = 8'd0;
        rready = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("c0_busy0", 16'(busy), 16'd1);
        chk("c0_done0", 16'(done), 16'd0);
        chk("c0_rv0", 16'(rvalid), 16'd0);
        step();
        chk("c0_busy1", 16'(busy), 16'd1);
        chk("c0_done1", 16'(done), 16'd1);
        chk("c0_rv1", 16'(rvalid), 16'd0);
        step();
        chk("c0_busy2", 16'(busy), 16'd0);
        chk("c0_done2", 16'(done), 16'd0);
        chk("c0_rv2", 16'(rvalid), 16'd0);

        // asynchronous reset while a result is pending
        init   = 16'h0010;
        delta  = 16'h0004;
        count  = 8'd5;
        sat    = 1'b1;
        rready = 1'b0;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ar_rv_pre", 16'(rvalid), 16'd1);
        chk("ar_r_pre", r, 16'h000C);
        #2 resetl = 1'b0;
        #1;
        chk("ar_busy", 16'(busy), 16'd0);
        chk("ar_rvalid", 16'(rvalid), 16'd0);
        chk("ar_r", r, 16'h0000);
        chk("ar_rsat", 16'(rsat), 16'd0);
        chk("ar_done", 16'(done), 16'd0);
        step();
        chk("ar_done_hold", 16'(done), 16'd0);
        resetl = 1'b1;
        step();
        run("after_rst", 16'h0010, 16'h0004, 8'd5, 1'b1, 1'b0,
            '{16'h000C, 16'h0008, 16'h0004, 16'h0000, 16'h0000},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
